// File: rtl/mem_wb_pipe_stage.sv
// mem_wb_pipe_stage
//   MEM->WB pipeline register with valid/ready flow control, flush and an
//   optional 2-entry skid buffer. Sits between the data-memory stage and the
//   register-file write port and also presents the selected writeback value.
//
//   Handshake: a transfer happens on a rising clk edge when valid and ready
//   are both high on that side. Payloads only change on a transfer. While
//   out_valid & !out_ready the head payload is held stable.
//
// Parameters
//   DATA_W : width of read-data, ALU-result and writeback-data paths
//   RD_W   : destination register index width
//   SKID   : 1 = 2-entry skid buffer, in_ready registered
//            0 = single register, in_ready combinational
//
// Ports
//   clk, rst          : clock, asynchronous active-high reset
//   flush             : discard held and incoming entries this cycle
//   in_valid/in_ready : upstream handshake
//   in_rdata, in_alures, in_rd, in_memtoreg, in_regwrite : upstream payload
//   out_valid/out_ready : writeback handshake
//   out_rdata, out_alures, out_rd : head payload (held on bubbles)
//   out_memtoreg, out_regwrite    : head controls, forced to 0 on bubbles
//   out_wbdata        : out_memtoreg ? out_rdata : out_alures
module mem_wb_pipe_stage #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 4,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_rdata,
    input  logic [DATA_W-1:0] in_alures,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              in_memtoreg,
    input  logic              in_regwrite,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_rdata,
    output logic [DATA_W-1:0] out_alures,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_memtoreg,
    output logic              out_regwrite,
    output logic [DATA_W-1:0] out_wbdata
);

    localparam int PW = 2 * DATA_W + RD_W + 2;

    // Occupancy states of the skid variant: (head, skid) = (0,0) (1,0) (1,1)
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    logic [PW-1:0]     in_payload;
    logic [PW-1:0]     head_q;
    logic              head_valid;
    logic [DATA_W-1:0] head_rdata;
    logic [DATA_W-1:0] head_alures;
    logic [RD_W-1:0]   head_rd;
    logic              head_memtoreg;
    logic              head_regwrite;

    assign in_payload = {in_rdata, in_alures, in_rd, in_memtoreg, in_regwrite};
    assign {head_rdata, head_alures, head_rd, head_memtoreg, head_regwrite} = head_q;

    generate
        if (SKID != 0) begin : g_skid
            state_t        state;
            logic [PW-1:0] skid_q;
            logic          ready_q;
            logic          push;

            assign push       = in_valid & ready_q;
            assign head_valid = (state != ST_EMPTY);
            // Registered ready: low exactly while the skid slot is occupied.
            assign in_ready   = ready_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state   <= ST_EMPTY;
                    head_q  <= '0;
                    skid_q  <= '0;
                    ready_q <= 1'b1;
                end else if (flush) begin
                    // Payload registers keep their contents; only occupancy drops.
                    state   <= ST_EMPTY;
                    ready_q <= 1'b1;
                end else begin
                    unique case (state)
                        ST_EMPTY: begin
                            if (push) begin
                                head_q <= in_payload;
                                state  <= ST_ONE;
                            end
                        end
                        ST_ONE: begin
                            if (push && out_ready) begin
                                head_q <= in_payload;
                            end else if (push) begin
                                skid_q  <= in_payload;
                                state   <= ST_TWO;
                                ready_q <= 1'b0;
                            end else if (out_ready) begin
                                state <= ST_EMPTY;
                            end
                        end
                        ST_TWO: begin
                            // Skid always holds the younger entry; promote it.
                            if (out_ready) begin
                                head_q  <= skid_q;
                                state   <= ST_ONE;
                                ready_q <= 1'b1;
                            end
                        end
                        default: begin
                            state   <= ST_EMPTY;
                            ready_q <= 1'b1;
                        end
                    endcase
                end
            end
        end else begin : g_noskid
            logic valid_q;

            assign head_valid = valid_q;
            assign in_ready   = ~valid_q | out_ready;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_q <= 1'b0;
                    head_q  <= '0;
                end else if (flush) begin
                    valid_q <= 1'b0;
                end else if (in_valid && in_ready) begin
                    valid_q <= 1'b1;
                    head_q  <= in_payload;
                end else if (out_ready) begin
                    valid_q <= 1'b0;
                end
            end
        end
    endgenerate

    assign out_valid    = head_valid;
    assign out_rdata    = head_rdata;
    assign out_alures   = head_alures;
    assign out_rd       = head_rd;
    // Controls are gated so a bubble can never write the register file.
    assign out_memtoreg = head_memtoreg & head_valid;
    assign out_regwrite = head_regwrite & head_valid;
    assign out_wbdata   = out_memtoreg ? head_rdata : head_alures;

endmodule

// File: tb/tb_mem_wb_pipe_stage.sv
// Bench for mem_wb_pipe_stage: one instance with default parameters (skid
// buffer) and one with SKID=0, DATA_W=64, RD_W=5. A queue model per instance
// predicts outputs each cycle; directed sequences add literal expectations.
module tb_mem_wb_pipe_stage;

    typedef struct packed {
        logic [63:0] rdata;
        logic [63:0] alures;
        logic [4:0]  rd;
        logic        mtr;
        logic        rw;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    // instance 1: SKID=1, DATA_W=32, RD_W=4
    logic        flush1 = 0, in_valid1 = 0, in_mtr1 = 0, in_rw1 = 0, out_ready1 = 0;
    logic [31:0] in_rdata1 = 0, in_alures1 = 0;
    logic [3:0]  in_rd1 = 0;
    logic        in_ready1, out_valid1, out_mtr1, out_rw1;
    logic [31:0] out_rdata1, out_alures1, out_wbdata1;
    logic [3:0]  out_rd1;

    // instance 0: SKID=0, DATA_W=64, RD_W=5
    logic        flush0 = 0, in_valid0 = 0, in_mtr0 = 0, in_rw0 = 0, out_ready0 = 0;
    logic [63:0] in_rdata0 = 0, in_alures0 = 0;
    logic [4:0]  in_rd0 = 0;
    logic        in_ready0, out_valid0, out_mtr0, out_rw0;
    logic [63:0] out_rdata0, out_alures0, out_wbdata0;
    logic [4:0]  out_rd0;

    always #5 clk = ~clk;

    mem_wb_pipe_stage dut1 (
        .clk(clk), .rst(rst), .flush(flush1),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .in_rdata(in_rdata1), .in_alures(in_alures1), .in_rd(in_rd1),
        .in_memtoreg(in_mtr1), .in_regwrite(in_rw1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .out_rdata(out_rdata1), .out_alures(out_alures1), .out_rd(out_rd1),
        .out_memtoreg(out_mtr1), .out_regwrite(out_rw1), .out_wbdata(out_wbdata1)
    );

    mem_wb_pipe_stage #(.DATA_W(64), .RD_W(5), .SKID(0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush0),
        .in_valid(in_valid0), .in_ready(in_ready0),
        .in_rdata(in_rdata0), .in_alures(in_alures0), .in_rd(in_rd0),
        .in_memtoreg(in_mtr0), .in_regwrite(in_rw0),
        .out_valid(out_valid0), .out_ready(out_ready0),
        .out_rdata(out_rdata0), .out_alures(out_alures0), .out_rd(out_rd0),
        .out_memtoreg(out_mtr0), .out_regwrite(out_rw0), .out_wbdata(out_wbdata0)
    );

    // ---------------- scoreboard / model ----------------
    ent_t q1[$];
    ent_t q0[$];
    ent_t last1 = '0;
    ent_t last0 = '0;
    bit   pop1, push1, pop0, push0;

    function automatic ent_t cur_in1();
        ent_t e;
        e.rdata = {32'h0, in_rdata1}; e.alures = {32'h0, in_alures1};
        e.rd = {1'b0, in_rd1}; e.mtr = in_mtr1; e.rw = in_rw1;
        return e;
    endfunction

    function automatic ent_t cur_in0();
        ent_t e;
        e.rdata = in_rdata0; e.alures = in_alures0;
        e.rd = in_rd0; e.mtr = in_mtr0; e.rw = in_rw0;
        return e;
    endfunction

    // Capacity-2 FIFO, input accepted whenever fewer than two entries held.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q1.delete();
            last1 = '0;
        end else begin
            pop1  = (q1.size() > 0) && out_ready1;
            push1 = in_valid1 && (q1.size() < 2);
            if (flush1) q1.delete();
            else begin
                if (pop1) void'(q1.pop_front());
                if (push1) q1.push_back(cur_in1());
            end
            if (q1.size() > 0) last1 = q1[0];
        end
    end

    // Capacity-1 register, input accepted if empty or head leaving now.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q0.delete();
            last0 = '0;
        end else begin
            pop0  = (q0.size() > 0) && out_ready0;
            push0 = in_valid0 && ((q0.size() == 0) || out_ready0);
            if (flush0) q0.delete();
            else begin
                if (pop0) void'(q0.pop_front());
                if (push0) q0.push_back(cur_in0());
            end
            if (q0.size() > 0) last0 = q0[0];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
        end
    endtask

    ent_t h1, h0;
    bit   v1, v0;

    always @(negedge clk) begin
        v1 = q1.size() > 0;
        h1 = v1 ? q1[0] : last1;
        chk("m1_out_valid", {63'h0, out_valid1}, {63'h0, v1});
        chk("m1_in_ready", {63'h0, in_ready1}, {63'h0, q1.size() < 2});
        chk("m1_out_rd", {60'h0, out_rd1}, {60'h0, h1.rd[3:0]});
        chk("m1_out_rdata", {32'h0, out_rdata1}, {32'h0, h1.rdata[31:0]});
        chk("m1_out_alures", {32'h0, out_alures1}, {32'h0, h1.alures[31:0]});
        chk("m1_out_regwrite", {63'h0, out_rw1}, {63'h0, v1 & h1.rw});
        chk("m1_out_memtoreg", {63'h0, out_mtr1}, {63'h0, v1 & h1.mtr});
        chk("m1_out_wbdata", {32'h0, out_wbdata1},
            {32'h0, (v1 & h1.mtr) ? h1.rdata[31:0] : h1.alures[31:0]});

        v0 = q0.size() > 0;
        h0 = v0 ? q0[0] : last0;
        chk("m0_out_valid", {63'h0, out_valid0}, {63'h0, v0});
        chk("m0_in_ready", {63'h0, in_ready0}, {63'h0, (q0.size() == 0) || out_ready0});
        chk("m0_out_rd", {59'h0, out_rd0}, {59'h0, h0.rd});
        chk("m0_out_rdata", out_rdata0, h0.rdata);
        chk("m0_out_alures", out_alures0, h0.alures);
        chk("m0_out_regwrite", {63'h0, out_rw0}, {63'h0, v0 & h0.rw});
        chk("m0_out_memtoreg", {63'h0, out_mtr0}, {63'h0, v0 & h0.mtr});
        chk("m0_out_wbdata", out_wbdata0, (v0 & h0.mtr) ? h0.rdata : h0.alures);
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive1(input logic v, input logic [3:0] rd, input logic [31:0] alu,
                          input logic [31:0] rdat, input logic mtr);
        in_valid1 = v; in_rd1 = rd; in_alures1 = alu; in_rdata1 = rdat;
        in_mtr1 = mtr; in_rw1 = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Streaming with out_ready high: 1-cycle latency, no gaps.
        out_ready1 = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive1(1'b1, 4'(i), 32'h100 + 32'(i), $urandom(), 1'b0);
            tick();
            chk("stream_valid", {63'h0, out_valid1}, 64'd1);
            chk("stream_rd", {60'h0, out_rd1}, 64'(i));
            chk("stream_alures", {32'h0, out_alures1}, 64'h100 + 64'(i));
        end

        // Writeback mux select.
        drive1(1'b1, 4'd7, 32'h12, 32'hDEADBEEF, 1'b1);
        tick();
        chk("wb_mux_rdata", {32'h0, out_wbdata1}, 64'hDEADBEEF);
        drive1(1'b1, 4'd7, 32'h12, 32'hDEADBEEF, 1'b0);
        tick();
        chk("wb_mux_alures", {32'h0, out_wbdata1}, 64'h12);
        in_valid1 = 1'b0;
        tick();
        chk("bubble_valid", {63'h0, out_valid1}, 64'd0);
        chk("bubble_regwrite", {63'h0, out_rw1}, 64'd0);
        chk("bubble_rd_held", {60'h0, out_rd1}, 64'd7);

        // Stall into the skid slot, then drain in order.
        out_ready1 = 1'b0;
        drive1(1'b1, 4'd3, 32'hA, 32'h0, 1'b0);
        tick();
        chk("stall_a_rd", {60'h0, out_rd1}, 64'd3);
        chk("stall_a_ready", {63'h0, in_ready1}, 64'd1);
        drive1(1'b1, 4'd5, 32'hB, 32'h0, 1'b0);
        tick();
        chk("stall_b_ready", {63'h0, in_ready1}, 64'd0);
        chk("stall_hold_a", {60'h0, out_rd1}, 64'd3);
        drive1(1'b1, 4'd9, 32'hC, 32'h0, 1'b0);
        tick();
        chk("stall_c_blocked", {63'h0, in_ready1}, 64'd0);
        chk("stall_still_a", {32'h0, out_alures1}, 64'hA);
        out_ready1 = 1'b1;
        tick();
        chk("drain_b", {60'h0, out_rd1}, 64'd5);
        chk("drain_ready", {63'h0, in_ready1}, 64'd1);
        tick();
        chk("drain_c", {60'h0, out_rd1}, 64'd9);
        in_valid1 = 1'b0;
        tick();
        chk("drain_empty", {63'h0, out_valid1}, 64'd0);

        // Flush while two entries held and a third is offered.
        out_ready1 = 1'b0;
        drive1(1'b1, 4'd1, 32'hD, 32'h0, 1'b1);
        tick();
        drive1(1'b1, 4'd2, 32'hE, 32'h0, 1'b1);
        tick();
        drive1(1'b1, 4'd4, 32'hF, 32'h0, 1'b1);
        flush1 = 1'b1;
        tick();
        chk("flush_valid", {63'h0, out_valid1}, 64'd0);
        chk("flush_regwrite", {63'h0, out_rw1}, 64'd0);
        chk("flush_ready", {63'h0, in_ready1}, 64'd1);
        flush1 = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b1;
        tick();
        tick();
        chk("flush_none_emerge", {63'h0, out_valid1}, 64'd0);

        // Asynchronous reset mid-stream.
        drive1(1'b1, 4'd6, 32'h66, 32'h0, 1'b0);
        tick();
        in_valid1 = 1'b0;
        rst = 1'b1;
        #2;
        chk("rst_valid", {63'h0, out_valid1}, 64'd0);
        chk("rst_regwrite", {63'h0, out_rw1}, 64'd0);
        chk("rst_rd", {60'h0, out_rd1}, 64'd0);
        chk("rst_ready", {63'h0, in_ready1}, 64'd1);
        tick();
        rst = 1'b0;
        tick();

        // Single-register variant: combinational ready, wide payload.
        out_ready0 = 1'b0;
        in_valid0 = 1'b1; in_rd0 = 5'd31; in_alures0 = 64'hFFFF_FFFF_0000_0001;
        in_rdata0 = 64'h0123_4567_89AB_CDEF; in_mtr0 = 1'b0; in_rw0 = 1'b1;
        tick();
        in_valid0 = 1'b0;
        #1;
        chk("s0_ready_low", {63'h0, in_ready0}, 64'd0);
        chk("s0_rd31", {59'h0, out_rd0}, 64'd31);
        chk("s0_alures", out_alures0, 64'hFFFF_FFFF_0000_0001);
        chk("s0_wbdata", out_wbdata0, 64'hFFFF_FFFF_0000_0001);
        out_ready0 = 1'b1;
        #1;
        chk("s0_ready_comb", {63'h0, in_ready0}, 64'd1);
        tick();
        chk("s0_drained", {63'h0, out_valid0}, 64'd0);

        // Randomised traffic on both instances.
        for (int c = 0; c < 3000; c++) begin
            in_valid1  = ($urandom_range(0, 99) < 65);
            out_ready1 = ($urandom_range(0, 99) < 60);
            flush1     = ($urandom_range(0, 99) < 4);
            in_rdata1  = $urandom(); in_alures1 = $urandom();
            in_rd1     = 4'($urandom_range(0, 15));
            in_mtr1    = 1'($urandom_range(0, 1)); in_rw1 = 1'($urandom_range(0, 1));
            in_valid0  = ($urandom_range(0, 99) < 65);
            out_ready0 = ($urandom_range(0, 99) < 60);
            flush0     = ($urandom_range(0, 99) < 4);
            in_rdata0  = {$urandom(), $urandom()}; in_alures0 = {$urandom(), $urandom()};
            in_rd0     = 5'($urandom_range(0, 31));
            in_mtr0    = 1'($urandom_range(0, 1)); in_rw0 = 1'($urandom_range(0, 1));
            tick();
        end
        in_valid1 = 0; in_valid0 = 0; flush1 = 0; flush0 = 0;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
